// File: rtl/nmr_acc_pkg.sv
// Purpose : shared types, default widths and arithmetic helpers for the NMR echo accumulator.
// Latency : n/a (combinational helper functions only).
// Backpr. : n/a.
package nmr_acc_pkg;

    localparam int ADC_DATA_WIDTH_DEF = 16;
    localparam int ACC_WIDTH_DEF      = 24;
    localparam int DATABUS_WIDTH_DEF  = 32;
    localparam int ADDR_WIDTH_DEF     = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Sign-extend the low w bits of v to 64 bits (w < 64).
    function automatic logic signed [63:0] sext64(input logic [63:0] v, input int w);
        logic [63:0] mask;
        logic [63:0] sign;
        mask = (64'd1 << w) - 64'd1;
        sign = 64'd1 << (w - 1);
        return signed'(((v & mask) ^ sign) - sign);
    endfunction

    // a + b clamped to the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r  = s;
        if (s > hi) begin
            r = hi;
        end else if (s < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/nmr_acc_ram.sv
// Purpose : simple dual-port echo buffer, one write port and one read port, no reset.
// Latency : read data registered, valid one cycle after rd_addr; read-first on address collision.
// Backpr. : none; caller holds rd_addr to hold rd_dat.
// Ports   : clk; wr_en/wr_addr/wr_dat write port; rd_addr/rd_dat read port.
module nmr_acc_ram #(
    parameter int DW = 24,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dat
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/nmr_echo_accumulator.sv
// Purpose : sums corresponding samples of every echo in a CPMG scan, then drains the summed record.
// Latency : sample written on the edge it is accepted; first OUT_VALID 2 cycles after last sample.
// Backpr. : OUT_DATA held while OUT_VALID && !OUT_READY; one word per cycle with OUT_READY high.
// Ports   : ADC_CLK/RESET_N; START + SAMPLES_PER_ECHO/ECHO_PER_SCAN config; DATA_IN/DATA_VALID input;
//           OUT_DATA/OUT_VALID/OUT_READY output stream; BUSY, DONE, OVERRUN status.
// Option  : define NMR_ECHO_ACC_SATURATE_EN for clamped accumulation (default wraps).
module nmr_echo_accumulator
    import nmr_acc_pkg::*;
#(
    parameter int ADC_DATA_WIDTH = ADC_DATA_WIDTH_DEF,
    parameter int ACC_WIDTH      = ACC_WIDTH_DEF,
    parameter int DATABUS_WIDTH  = DATABUS_WIDTH_DEF,
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF
) (
    input  logic                      ADC_CLK,
    input  logic                      RESET_N,
    input  logic                      START,
    input  logic [DATABUS_WIDTH-1:0]  SAMPLES_PER_ECHO,
    input  logic [DATABUS_WIDTH-1:0]  ECHO_PER_SCAN,
    input  logic [ADC_DATA_WIDTH-1:0] DATA_IN,
    input  logic                      DATA_VALID,
    output logic [DATABUS_WIDTH-1:0]  OUT_DATA,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      OVERRUN
);

    localparam int MAX_SAMPLES = 1 << ADDR_WIDTH;
    // One extra bit so the sample counter can represent N == MAX_SAMPLES.
    localparam int CW = ADDR_WIDTH + 1;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]            n_cfg;
    logic [CW-1:0]            n_start;
    logic [CW-1:0]            k;
    logic [CW-1:0]            k_nxt;
    logic [DATABUS_WIDTH-1:0] e_cfg;
    logic [DATABUS_WIDTH-1:0] e_idx;
    logic [DATABUS_WIDTH-1:0] e_nxt;
    logic                     start_empty;

    logic                     wr_en;
    logic [ADDR_WIDTH-1:0]    wr_addr;
    logic [ADDR_WIDTH-1:0]    rd_addr;
    logic [ACC_WIDTH-1:0]     wr_dat;
    logic [ACC_WIDTH-1:0]     ram_rd;
    logic [ACC_WIDTH-1:0]     rd_eff;
    logic [ACC_WIDTH-1:0]     din_ext;
    logic [ACC_WIDTH-1:0]     acc_sum;
    logic                     fwd_hit;
    logic [ACC_WIDTH-1:0]     fwd_dat;

    logic                     out_vld;
    logic [DATABUS_WIDTH-1:0] out_dat;
    logic                     overrun;

    logic acc_fire;
    logic last_k;
    logic last_e;
    logic load;
    logic rvld;
    logic drain_fire;
    logic drain_end;

    assign n_start     = (SAMPLES_PER_ECHO > MAX_SAMPLES) ? CW'(MAX_SAMPLES)
                                                          : SAMPLES_PER_ECHO[CW-1:0];
    assign start_empty = (n_start == '0) || (ECHO_PER_SCAN == '0);

    assign acc_fire   = (state == ST_ACCUM) && DATA_VALID && !START;
    assign last_k     = (k == n_cfg - CW'(1));
    assign last_e     = (e_idx == e_cfg - DATABUS_WIDTH'(1));
    // Output register can take a new word when empty or being consumed this edge.
    assign load       = !out_vld || OUT_READY;
    // In DRAIN the RAM output always holds buf[k]; it is a real word until k reaches N.
    assign rvld       = (k < n_cfg);
    assign drain_fire = (state == ST_DRAIN) && load && rvld && !START;
    assign drain_end  = (state == ST_DRAIN) && (k == n_cfg) && out_vld && OUT_READY;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge ADC_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        if (START) begin
            state_nxt = start_empty ? ST_DONE : ST_ACCUM;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_IDLE;
                ST_ACCUM: if (acc_fire && last_k && last_e) state_nxt = ST_DRAIN;
                ST_DRAIN: if (drain_end) state_nxt = ST_DONE;
                ST_DONE:  state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        BUSY = (state == ST_ACCUM) || (state == ST_DRAIN);
        DONE = (state == ST_DONE);
    end

    // ---------------- index counters ----------------
    always_comb begin
        k_nxt = k;
        e_nxt = e_idx;
        if (START) begin
            k_nxt = '0;
            e_nxt = '0;
        end else if (acc_fire) begin
            if (last_k) begin
                k_nxt = '0;
                e_nxt = e_idx + DATABUS_WIDTH'(1);
            end else begin
                k_nxt = k + CW'(1);
            end
        end else if (drain_fire) begin
            k_nxt = k + CW'(1);
        end
    end

    // Read the index we will need next cycle so a read is always outstanding.
    assign rd_addr = k_nxt[ADDR_WIDTH-1:0];

    always_ff @(posedge ADC_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            k     <= '0;
            e_idx <= '0;
            n_cfg <= '0;
            e_cfg <= '0;
        end else begin
            k     <= k_nxt;
            e_idx <= e_nxt;
            if (START) begin
                n_cfg <= n_start;
                e_cfg <= ECHO_PER_SCAN;
            end
        end
    end

    // ---------------- accumulate datapath ----------------
    assign din_ext = ACC_WIDTH'(sext64(64'(DATA_IN), ADC_DATA_WIDTH));
    // A write to the address being read on the same edge is missed by the RAM; bypass it.
    assign rd_eff  = fwd_hit ? fwd_dat : ram_rd;

`ifdef NMR_ECHO_ACC_SATURATE_EN
    assign acc_sum = ACC_WIDTH'(sat_add(sext64(64'(rd_eff), ACC_WIDTH),
                                        sext64(64'(DATA_IN), ADC_DATA_WIDTH), ACC_WIDTH));
`else
    assign acc_sum = rd_eff + din_ext;
`endif

    // Echo 0 overwrites, so stale contents never need a clear pass.
    assign wr_en   = acc_fire;
    assign wr_addr = k[ADDR_WIDTH-1:0];
    assign wr_dat  = (e_idx == '0) ? din_ext : acc_sum;

    always_ff @(posedge ADC_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fwd_hit <= 1'b0;
            fwd_dat <= '0;
        end else begin
            fwd_hit <= wr_en && (wr_addr == rd_addr);
            fwd_dat <= wr_dat;
        end
    end

    nmr_acc_ram #(
        .DW (ACC_WIDTH),
        .AW (ADDR_WIDTH)
    ) u_ram (
        .clk     (ADC_CLK),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_dat  (wr_dat),
        .rd_addr (rd_addr),
        .rd_dat  (ram_rd)
    );

    // ---------------- output register and status ----------------
    always_ff @(posedge ADC_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_vld <= 1'b0;
            out_dat <= '0;
            overrun <= 1'b0;
        end else begin
            if (START) begin
                out_vld <= 1'b0;
            end else if (state == ST_DRAIN) begin
                if (load) begin
                    out_vld <= rvld;
                    if (rvld) begin
                        out_dat <= DATABUS_WIDTH'(sext64(64'(rd_eff), ACC_WIDTH));
                    end
                end
            end else begin
                out_vld <= 1'b0;
            end

            if (START) begin
                overrun <= 1'b0;
            end else if (DATA_VALID && (state != ST_ACCUM)) begin
                overrun <= 1'b1;
            end
        end
    end

    assign OUT_DATA  = out_dat;
    assign OUT_VALID = out_vld;
    assign OVERRUN   = overrun;

endmodule

// File: tb/tb_nmr_echo_accumulator.sv
// Purpose : self-checking bench for nmr_echo_accumulator against an arithmetic reference model.
// Latency : checks drain start latency, DONE timing and output handshake stability.
// Backpr. : drives OUT_READY always-high, 1-0-0-1 and random patterns.
module tb_nmr_echo_accumulator;

    localparam int ADW  = 16;
    localparam int ACCW = 18;
    localparam int DBW  = 32;
    localparam int AW   = 4;
    localparam int MAXS = 1 << AW;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [DBW-1:0]  spe   = '0;
    logic [DBW-1:0]  eps   = '0;
    logic [ADW-1:0]  din   = '0;
    logic            dvld  = 1'b0;
    logic            ordy  = 1'b0;
    logic [DBW-1:0]  odata;
    logic            ovld;
    logic            busy;
    logic            done;
    logic            ovr;

    int              tests = 0;
    int              fails = 0;
    logic [DBW-1:0]  last_word = '0;

    always #5 clk = ~clk;

    nmr_echo_accumulator #(
        .ADC_DATA_WIDTH (ADW),
        .ACC_WIDTH      (ACCW),
        .DATABUS_WIDTH  (DBW),
        .ADDR_WIDTH     (AW)
    ) dut (
        .ADC_CLK          (clk),
        .RESET_N          (rst_n),
        .START            (start),
        .SAMPLES_PER_ECHO (spe),
        .ECHO_PER_SCAN    (eps),
        .DATA_IN          (din),
        .DATA_VALID       (dvld),
        .OUT_DATA         (odata),
        .OUT_VALID        (ovld),
        .OUT_READY        (ordy),
        .BUSY             (busy),
        .DONE             (done),
        .OVERRUN          (ovr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference accumulation: exact sum reduced to the ACCW-bit signed range.
    function automatic longint acc_add(input longint a, input longint b);
        longint s;
        longint hi;
        longint lo;
        s  = a + b;
        hi = (longint'(1) <<< (ACCW - 1)) - 1;
        lo = -hi - 1;
`ifdef NMR_ECHO_ACC_SATURATE_EN
        if (s > hi) s = hi;
        else if (s < lo) s = lo;
`else
        s = s & ((longint'(1) <<< ACCW) - 1);
        if (s > hi) s = s - (longint'(1) <<< ACCW);
`endif
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a scan and feed 'count' samples of the 10e+k pattern, back to back.
    task automatic feed(input int n, input int e, input int count);
        spe = n; eps = e; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < count; i++) begin
            din  = 16'(10 * (i / n) + (i % n));
            dvld = 1'b1;
            step();
        end
        dvld = 1'b0;
    endtask

    // dmode: 0 = 10e+k, 1 = constant cval, 2 = random. rmode: 0 = ready, 1 = 1-0-0-1, 2 = random.
    task automatic run_scan(input string tag, input int n_cfg, input int e_cnt, input int dmode,
                            input int cval, input bit gaps, input int rmode, input bit ovr_inject);
        int          n;
        longint      expv[$];
        int          got;
        int          cyc;
        int          lat;
        bit          prev_stall;
        bit          prev_xfer;
        bit          seen_done;
        logic [31:0] prev_dat;
        logic [15:0] v;
        n = (n_cfg > MAXS) ? MAXS : n_cfg;
        got = 0; cyc = 0; lat = -1;
        prev_stall = 1'b0; prev_xfer = 1'b0; seen_done = 1'b0; prev_dat = '0;
        for (int k = 0; k < n; k++) expv.push_back(0);

        spe = n_cfg; eps = e_cnt; start = 1'b1;
        step();
        start = 1'b0;
        check({tag, ":busy_after_start"}, busy, 1);
        check({tag, ":ovld_after_start"}, ovld, 0);
        check({tag, ":ovr_cleared"}, ovr, 0);

        for (int e = 0; e < e_cnt; e++) begin
            for (int k = 0; k < n; k++) begin
                if (gaps) begin
                    while ($urandom_range(0, 3) == 0) begin
                        dvld = 1'b0;
                        step();
                    end
                end
                v = (dmode == 0) ? 16'(10 * e + k) : (dmode == 1) ? 16'(cval) : 16'($urandom);
                din  = v;
                dvld = 1'b1;
                expv[k] = (e == 0) ? longint'($signed(v)) : acc_add(expv[k], longint'($signed(v)));
                step();
            end
        end
        dvld = 1'b0;

        while (!seen_done && cyc < 200) begin
            cyc++;
            if (ovld && lat < 0) lat = cyc;
            if (prev_stall) begin
                check({tag, ":stall_valid"}, ovld, 1);
                check({tag, ":stall_data"}, odata, prev_dat);
            end
            if (ovr_inject && cyc == 3) check({tag, ":overrun_set"}, ovr, 1);
            if (done) begin
                seen_done = 1'b1;
                check({tag, ":done_after_last_xfer"}, 32'(prev_xfer && got == n), 1);
                check({tag, ":busy_at_done"}, busy, 0);
                check({tag, ":ovld_at_done"}, ovld, 0);
            end else begin
                case (rmode)
                    0:       ordy = 1'b1;
                    1:       ordy = ((got + cyc) % 4 == 0) || ((got + cyc) % 4 == 3);
                    default: ordy = 1'($urandom_range(0, 1));
                endcase
                dvld = ovr_inject && (cyc == 2);
                din  = 16'($urandom);
                prev_xfer  = ovld && ordy;
                prev_stall = ovld && !ordy;
                prev_dat   = odata;
                if (ovld && ordy) begin
                    if (got < n) check({tag, ":word"}, odata, 32'(expv[got]));
                    else         check({tag, ":extra_word"}, got, n);
                    last_word = odata;
                    got++;
                end
                step();
            end
        end
        dvld = 1'b0;
        ordy = 1'b0;
        check({tag, ":done_seen"}, seen_done, 1);
        check({tag, ":word_count"}, got, n);
        check({tag, ":drain_latency"}, lat, 2);
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        check("rst:out_data", odata, 0);
        check("rst:out_valid", ovld, 0);
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:overrun", ovr, 0);
        rst_n = 1'b1;
        step();

        // Data while idle sets the sticky flag
        dvld = 1'b1; din = 16'h1234;
        step();
        dvld = 1'b0;
        step();
        check("idle_ovr:set", ovr, 1);
        check("idle_ovr:held", busy, 0);

        // Empty config goes straight to DONE and clears OVERRUN
        spe = 0; eps = 3; start = 1'b1;
        step();
        start = 1'b0;
        check("empty:done", done, 1);
        check("empty:busy", busy, 0);
        check("empty:ovr_cleared", ovr, 0);
        step();
        check("empty:done_pulse", done, 0);

        run_scan("basic", 4, 3, 0, 0, 1'b0, 0, 1'b0);
        check("basic:last", last_word, 39);
        check("basic:overrun", ovr, 0);

        run_scan("fwd", 1, 5, 1, 7, 1'b0, 0, 1'b0);
        check("fwd:value", last_word, 35);

        run_scan("bp", 4, 3, 0, 0, 1'b0, 1, 1'b0);
        check("bp:last", last_word, 39);

        run_scan("sat", 1, 8, 1, 'h7FFF, 1'b0, 0, 1'b0);
`ifdef NMR_ECHO_ACC_SATURATE_EN
        check("sat:value", last_word, 32'd131071);
`else
        check("sat:value", last_word, 32'hFFFF_FFF8);
`endif

        run_scan("clamp_n", 100, 2, 2, 0, 1'b0, 0, 1'b0);

        // Abort during accumulation
        feed(4, 3, 6);
        check("abort_acc:busy", busy, 1);
        run_scan("abort_acc", 4, 3, 0, 0, 1'b0, 0, 1'b0);
        check("abort_acc:last", last_word, 39);

        // Abort during drain
        feed(4, 3, 12);
        ordy = 1'b1;
        repeat (3) step();
        check("abort_drain:mid_valid", ovld, 1);
        run_scan("abort_drain", 4, 3, 0, 0, 1'b0, 0, 1'b0);

        // Reset mid-drain
        feed(4, 3, 12);
        ordy = 1'b0;
        repeat (3) step();
        check("rst_drain:pre_valid", ovld, 1);
        rst_n = 1'b0;
        #1;
        check("rst_drain:out_data", odata, 0);
        check("rst_drain:out_valid", ovld, 0);
        check("rst_drain:busy", busy, 0);
        check("rst_drain:done", done, 0);
        check("rst_drain:overrun", ovr, 0);
        step();
        rst_n = 1'b1;
        repeat (2) step();
        check("rst_drain:idle_busy", busy, 0);
        check("rst_drain:idle_valid", ovld, 0);
        run_scan("post_rst", 4, 3, 0, 0, 1'b0, 0, 1'b0);

        // Overrun during drain; data unaffected, flag held until next START
        run_scan("ovr", 4, 3, 0, 0, 1'b0, 1, 1'b1);
        step();
        check("ovr:held", ovr, 1);

        // Randomized scans
        for (int i = 0; i < 4; i++) begin
            run_scan("rand", $urandom_range(1, 20), $urandom_range(1, 4), 2, 0, 1'b1, 2, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
